regfile_mp: RTL and testbench

- Parametrised multi-read-port register file, the next generation of the CPU's fixed 32x32, 2-read/1-write file.
- Adds:
  - configurable width, depth and read-port count;
  - optional write-to-read bypass;
  - optional hard-wired zero register;
  - per-register pending-write scoreboard so decode can stall on outstanding multi-cycle results (loads, mul/div).
- Sits in the decode stage between instruction decode, the hazard unit and writeback.

---
 rtl/rf_pkg.sv | 34 +++
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 83 ++++++++
 tb/tb_regfile_mp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants: default geometry, zero-register address,
// ABI register indices used by the decoder, and read-source selection.
package rf_pkg;

   localparam int RF_DATA_W    = 32;
   localparam int RF_ADDR_W    = 5;
   localparam int RF_NREAD     = 2;
   localparam int RF_ZERO_ADDR = 0;

   localparam int REG_ZERO = 0;
   localparam int REG_AT   = 1;
   localparam int REG_V0   = 2;
   localparam int REG_V1   = 3;
   localparam int REG_A0   = 4;
   localparam int REG_A1   = 5;
   localparam int REG_A2   = 6;
   localparam int REG_A3   = 7;
   localparam int REG_GP   = 28;
   localparam int REG_SP   = 29;
   localparam int REG_FP   = 30;
   localparam int REG_RA   = 31;

   typedef enum logic [1:0] {
      SRC_MEM    = 2'd0,
      SRC_BYPASS = 2'd1,
      SRC_ZERO   = 2'd2
   } rd_src_e;

   // True when addr names the hard-wired zero register of this configuration.
   function automatic logic is_zero_reg(input int zero_reg, input int addr);
      return (zero_reg != 0) && (addr == RF_ZERO_ADDR);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue of a
// long-latency producer, cleared by its writeback; set wins on collision.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NREAD    = RF_NREAD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wen,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic                    bset,
   input  logic [ADDR_W-1:0]       baddr,
   input  logic [NREAD*ADDR_W-1:0] raddr,
   output logic [NREAD-1:0]        rbusy,
   output logic                    busy_any
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (wen) busy_nxt[waddr] = 1'b0;
      // Applied after the clear so a same-cycle reissue keeps the register busy.
      if (bset && !is_zero_reg(ZERO_REG, int'(baddr))) busy_nxt[baddr] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[RF_ZERO_ADDR] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_port
      logic [ADDR_W-1:0] ra;
      logic              fwd;
      assign ra       = raddr[i*ADDR_W +: ADDR_W];
      // A port fed by the bypass this cycle already has its value.
      assign fwd      = (BYPASS != 0) && wen && (waddr == ra);
      assign rbusy[i] = busy[ra] & ~fwd;
   end

   assign busy_any = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional write bypass,
// optional hard-wired zero register and a pending-write scoreboard.
module regfile_mp
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NREAD    = RF_NREAD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREAD*ADDR_W-1:0] raddr,
   output logic [NREAD*DATA_W-1:0] rdata,
   output logic [NREAD-1:0]        rbusy,
   input  logic                    wen,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [DATA_W-1:0]       wdata,
   input  logic                    bset,
   input  logic [ADDR_W-1:0]       baddr,
   output logic                    busy_any
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;

   // Reset masks the write so it cannot leak through the bypass either.
   assign wr_ok = wen & ~reset & ~is_zero_reg(ZERO_REG, int'(waddr));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      rd_src_e           src;

      assign ra = raddr[i*ADDR_W +: ADDR_W];

      always_comb begin
         src = SRC_MEM;
         if (reset || is_zero_reg(ZERO_REG, int'(ra))) src = SRC_ZERO;
         else if ((BYPASS != 0) && wr_ok && (waddr == ra)) src = SRC_BYPASS;
      end

      always_comb begin
         rd = mem[ra];
         case (src)
            SRC_BYPASS: rd = wdata;
            SRC_ZERO:   rd = '0;
            default:    rd = mem[ra];
         endcase
      end

      assign rdata[i*DATA_W +: DATA_W] = rd;
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NREAD    (NREAD),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .wen      (wen),
      .waddr    (waddr),
      .bset     (bset),
      .baddr    (baddr),
      .raddr    (raddr),
      .rbusy    (rbusy),
      .busy_any (busy_any)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default build (bypass, zero reg) and a
// 4-port 16x8 build without bypass or zero reg, against an array model.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A: DATA_W=32, ADDR_W=5, NREAD=2, ZERO_REG=1, BYPASS=1
   logic [9:0]  a_raddr;
   logic [63:0] a_rdata;
   logic [1:0]  a_rbusy;
   logic        a_wen, a_bset, a_busy_any;
   logic [4:0]  a_waddr, a_baddr;
   logic [31:0] a_wdata;

   // Instance B: DATA_W=16, ADDR_W=3, NREAD=4, ZERO_REG=0, BYPASS=0
   logic [11:0] b_raddr;
   logic [63:0] b_rdata;
   logic [3:0]  b_rbusy;
   logic        b_wen, b_bset, b_busy_any;
   logic [2:0]  b_waddr, b_baddr;
   logic [15:0] b_wdata;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .reset(reset), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
      .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata), .bset(a_bset), .baddr(a_baddr),
      .busy_any(a_busy_any));

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .reset(reset), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
      .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .bset(b_bset), .baddr(b_baddr),
      .busy_any(b_busy_any));

   typedef struct {
      logic [63:0] a_rd;
      logic [1:0]  a_rb;
      logic        a_ba;
      logic [63:0] b_rd;
      logic [3:0]  b_rb;
      logic        b_ba;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Architectural model: register contents and outstanding-write flags.
   logic [31:0] ma [32];
   bit          bsa[32];
   logic [15:0] mb [8];
   bit          bsb[8];

   function automatic exp_t predict();
      exp_t e;
      e.a_rd = '0; e.a_rb = '0; e.a_ba = 1'b0;
      e.b_rd = '0; e.b_rb = '0; e.b_ba = 1'b0;
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            int r;
            logic [31:0] d;
            bit fwd;
            r   = int'(a_raddr[i*5 +: 5]);
            fwd = a_wen && (int'(a_waddr) == r) && (r != 0);
            if (r == 0)   d = 32'h0;
            else if (fwd) d = a_wdata;
            else          d = ma[r];
            e.a_rd[i*32 +: 32] = d;
            e.a_rb[i] = bsa[r] && !fwd;
         end
         for (int r = 0; r < 32; r++) if (bsa[r]) e.a_ba = 1'b1;
         for (int i = 0; i < 4; i++) begin
            int r;
            r = int'(b_raddr[i*3 +: 3]);
            e.b_rd[i*16 +: 16] = mb[r];
            e.b_rb[i] = bsb[r];
         end
         for (int r = 0; r < 8; r++) if (bsb[r]) e.b_ba = 1'b1;
      end
      return e;
   endfunction

   task automatic update_model();
      if (reset) begin
         for (int r = 0; r < 32; r++) begin ma[r] = '0; bsa[r] = 0; end
         for (int r = 0; r < 8; r++)  begin mb[r] = '0; bsb[r] = 0; end
      end else begin
         if (a_wen) begin
            if (a_waddr != 0) ma[a_waddr] = a_wdata;
            bsa[a_waddr] = 0;
         end
         if (a_bset && a_baddr != 0) bsa[a_baddr] = 1;
         if (b_wen) begin
            mb[b_waddr]  = b_wdata;
            bsb[b_waddr] = 0;
         end
         if (b_bset) bsb[b_baddr] = 1;
      end
   endtask

   task automatic tick();
      q.push_back(predict());
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic idle();
      a_wen = 0; a_bset = 0; b_wen = 0; b_bset = 0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("a_rdata",    a_rdata,               e.a_rd);
         chk("a_rbusy",    64'(a_rbusy),          64'(e.a_rb));
         chk("a_busy_any", 64'(a_busy_any),       64'(e.a_ba));
         chk("b_rdata",    b_rdata,               e.b_rd);
         chk("b_rbusy",    64'(b_rbusy),          64'(e.b_rb));
         chk("b_busy_any", 64'(b_busy_any),       64'(e.b_ba));
      end
   end

   initial begin
      for (int r = 0; r < 32; r++) begin ma[r] = '0; bsa[r] = 0; end
      for (int r = 0; r < 8; r++)  begin mb[r] = '0; bsb[r] = 0; end
      reset = 1; idle();
      a_raddr = '0; a_waddr = '0; a_wdata = '0; a_baddr = '0;
      b_raddr = '0; b_waddr = '0; b_wdata = '0; b_baddr = '0;
      @(posedge clk); #1;
      tick(); tick();
      reset = 0;

      // Post-reset sweep of every address
      for (int r = 0; r < 32; r++) begin
         a_raddr = {5'(31 - r), 5'(r)};
         b_raddr = {3'(r + 3), 3'(r + 2), 3'(r + 1), 3'(r)};
         tick();
      end

      // Reset coinciding with a write drops it
      a_wen = 1; a_waddr = 5; a_wdata = 32'hDEADBEEF; a_raddr = {5'd5, 5'd5};
      b_wen = 1; b_waddr = 5; b_wdata = 16'hBEEF;     b_raddr = {4{3'd5}};
      reset = 1; tick();
      reset = 0; idle(); tick();

      // Same-cycle write/read: forwarded on A, one cycle late on B
      a_wen = 1; a_waddr = 7; a_wdata = 32'h12345678; a_raddr = {5'd0, 5'd7};
      b_wen = 1; b_waddr = 7; b_wdata = 16'h5678;     b_raddr = {9'd0, 3'd7};
      tick();
      idle(); tick();

      // Writes and bset to register 0
      a_wen = 1; a_waddr = 0; a_wdata = 32'hFFFFFFFF; a_raddr = '0;
      b_wen = 1; b_waddr = 0; b_wdata = 16'hFFFF;     b_raddr = '0;
      tick();
      idle(); tick();
      a_bset = 1; a_baddr = 0; b_bset = 1; b_baddr = 0; tick();
      idle(); tick();
      b_wen = 1; b_waddr = 0; b_wdata = 16'h0; tick();
      idle(); tick();

      // bset r9, read on both ports, then write it back
      a_bset = 1; a_baddr = 9; a_raddr = {5'd9, 5'd9};
      b_bset = 1; b_baddr = 1; b_raddr = {4{3'd1}};
      tick();
      idle(); tick();
      a_wen = 1; a_waddr = 9; a_wdata = 32'hA5A5A5A5;
      b_wen = 1; b_waddr = 1; b_wdata = 16'hA5A5;
      tick();
      idle(); tick();

      // Same-cycle bset and write: set wins, later write clears
      a_bset = 1; a_baddr = 12; a_wen = 1; a_waddr = 12; a_wdata = 32'h55; a_raddr = {5'd12, 5'd12};
      b_bset = 1; b_baddr = 4;  b_wen = 1; b_waddr = 4;  b_wdata = 16'h55; b_raddr = {4{3'd4}};
      tick();
      idle(); tick();
      a_wen = 1; a_waddr = 12; a_wdata = 32'h66;
      b_wen = 1; b_waddr = 4;  b_wdata = 16'h66;
      tick();
      idle(); tick();

      // Four simultaneous reads on B
      for (int n = 1; n < 8; n++) begin
         b_wen = 1; b_waddr = 3'(n); b_wdata = 16'(16'h1111 * n);
         tick();
      end
      idle();
      b_raddr = {3'd7, 3'd5, 3'd3, 3'd1};
      tick();

      // Randomized traffic, addresses biased to a small set for collisions
      for (int c = 0; c < 3000; c++) begin
         reset   = ($urandom_range(0, 249) == 0);
         a_wen   = 1'($urandom_range(0, 1));
         a_bset  = ($urandom_range(0, 3) == 0);
         a_waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         a_baddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         a_wdata = $urandom;
         for (int i = 0; i < 2; i++)
            a_raddr[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         b_wen   = 1'($urandom_range(0, 1));
         b_bset  = ($urandom_range(0, 3) == 0);
         b_waddr = 3'($urandom);
         b_baddr = 3'($urandom);
         b_wdata = 16'($urandom);
         b_raddr = 12'($urandom);
         tick();
      end
      reset = 0; idle(); tick();

      @(negedge clk); #1;
      chk("queue_drained", 64'(q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
